// File: rtl/flag_stack_reg.sv
// flag_stack_reg: processor flag register with per-bit write mask
// and a LIFO save/restore stack for call/return and interrupt entry.
//
// Ports:
//   clk, rst      clock (rising edge), async active-high reset
//   we, wmask, d  masked flag write from the ALU
//   push, pop     save q to stack / restore q from stack top
//   clr_err       clear the sticky ovf_err/unf_err flags
//   q             registered flags
//   q_byp         next-edge flags when FLAG_STACK_BYPASS_EN is
//                 defined, otherwise identical to q
//   count         occupied stack entries
//   full, empty   decoded from the registered count
//   ovf_err       sticky: push while full
//   unf_err       sticky: pop while empty
//
// Build option: define FLAG_STACK_BYPASS_EN for the bypass path.

module flag_stack_reg #(
    parameter int                  WIDTH     = 4,
    parameter int                  DEPTH     = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [WIDTH-1:0]             wmask,
    input  logic [WIDTH-1:0]             d,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             q_byp,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_swap;
    logic             w_stk_we;
    logic [CW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_wr_val;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(DEPTH));

    // Any pop on a non-empty stack restores q (plain pop or swap).
    assign w_do_pop  = pop && !w_empty;
    assign w_swap    = push && pop && !w_empty;
    assign w_do_push = push && !pop && !w_full;
    assign w_stk_we  = w_do_push || w_swap;

    // Swap overwrites the top entry; plain push writes the next free one.
    assign w_wr_idx  = w_swap ? (r_cnt - CW'(1)) : r_cnt;

    assign w_ovf_set = push && !pop && w_full;
    assign w_unf_set = pop && w_empty;

    // Top-of-stack read, decoded so an empty stack never indexes out of range.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    assign w_wr_val = (r_q & ~wmask) | (d & wmask);

    // A successful pop/swap takes priority over the ALU write.
    always_comb begin
        w_q_nxt = r_q;
        if (w_do_pop) begin
            w_q_nxt = w_top;
        end else if (we) begin
            w_q_nxt = w_wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RESET_VAL;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_q <= w_q_nxt;
            if (w_do_push) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_do_pop && !push) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Set wins over a same-cycle clear.
            r_ovf <= w_ovf_set || (r_ovf && !clr_err);
            r_unf <= w_unf_set || (r_unf && !clr_err);
        end
    end

    // Stack storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_stk_we && (w_wr_idx == CW'(i))) begin
                r_stack[i] <= r_q;
            end
        end
    end

    assign q       = r_q;
    assign count   = r_cnt;
    assign full    = w_full;
    assign empty   = w_empty;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;

`ifdef FLAG_STACK_BYPASS_EN
    assign q_byp = w_q_nxt;
`else
    assign q_byp = r_q;
`endif

endmodule
